// File: rtl/seq_pkg.sv
// Shared definitions for the serial sequence interface: FSM states and the
// pin/field map used by both the generator and the detector tiles.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  localparam int BIT_CYCLES_DEFAULT = 4;

  // uio_in control fields
  localparam int LEN_LSB    = 0;
  localparam int LEN_W      = 3;
  localparam int START_BIT  = 3;
  localparam int REPEAT_BIT = 4;

  // uo_out pins
  localparam int SDATA_BIT  = 0;
  localparam int STROBE_BIT = 1;
  localparam int FRAME_BIT  = 2;
  localparam int IDX_LSB    = 4;
  localparam int IDX_W      = 4;

  // uio_out pins
  localparam int BUSY_BIT   = 7;
  localparam int DONE_BIT   = 6;

  localparam logic [7:0] UIO_OE_VALUE = 8'hC0;

endpackage

// File: rtl/seq_bit_timer.sv
// Per-bit period counter: counts 0..BIT_CYCLES-1 while running and wraps,
// flagging the terminal count so the FSM can advance to the next bit.
module seq_bit_timer #(
  parameter int BIT_CYCLES = 4,
  parameter int CW         = $clog2(BIT_CYCLES) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic          clear,
  input  logic          run,
  output logic [CW-1:0] count,
  output logic          tc
);

  assign tc = (count == CW'(BIT_CYCLES - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; ena gates the whole update so a disabled cycle freezes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (ena) begin
      if (clear)
        count <= '0;
      else if (run)
        count <= tc ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/tt_um_3515_sequence_generator.sv
// Serial bit-pattern transmitter: captures a 1-8 bit pattern on a start rise and
// shifts it out MSB-first, BIT_CYCLES clocks per bit, optionally repeating.
module tt_um_3515_sequence_generator
  import seq_pkg::*;
#(
  parameter int BIT_CYCLES = BIT_CYCLES_DEFAULT
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  localparam int CW = $clog2(BIT_CYCLES) + 1;

  seq_state_e         state_q, state_d;
  logic [LEN_W-1:0]   idx_q, idx_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [7:0]         pat_q, pat_d;
  logic               start_q;
  logic               rise;
  logic               timer_clear, timer_run;
  logic [CW-1:0]      count;
  logic               tc;
  logic               in_send;
  logic               unused_bits;

  assign unused_bits = ^uio_in[7:5];
  assign rise        = uio_in[START_BIT] & ~start_q;

  seq_bit_timer #(
    .BIT_CYCLES (BIT_CYCLES),
    .CW         (CW)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .clear (timer_clear),
    .run   (timer_run),
    .count (count),
    .tc    (tc)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    len_d       = len_q;
    pat_d       = pat_q;
    timer_clear = 1'b0;
    timer_run   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          pat_d       = ui_in;
          len_d       = uio_in[LEN_LSB +: LEN_W];
          idx_d       = uio_in[LEN_LSB +: LEN_W];
          timer_clear = 1'b1;
          state_d     = SEND;
        end
      end
      SEND: begin
        timer_run = 1'b1;
        if (tc) begin
          if (idx_q != '0)
            idx_d = idx_q - 1'b1;
          else if (uio_in[REPEAT_BIT])
            idx_d = len_q;  // timer wraps to 0, so the next frame starts with no gap
          else
            state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      pat_q   <= '0;
      start_q <= 1'b0;
    end else if (ena) begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      pat_q   <= pat_d;
      start_q <= uio_in[START_BIT];
    end
  end

  // Outputs are decoded only from flops, so inputs never reach a pin combinationally.
  assign in_send = (state_q == SEND);

  always_comb begin
    uo_out                     = '0;
    uo_out[SDATA_BIT]          = in_send & pat_q[idx_q];
    uo_out[STROBE_BIT]         = in_send & (count == '0);
    uo_out[FRAME_BIT]          = in_send;
    uo_out[IDX_LSB +: IDX_W]   = {1'b0, idx_q};
    uio_out                    = '0;
    uio_out[BUSY_BIT]          = (state_q != IDLE);
    uio_out[DONE_BIT]          = (state_q == DONE);
  end

  assign uio_oe = UIO_OE_VALUE;

endmodule

// File: tb/tb_tt_um_3515_sequence_generator.sv
// Self-checking bench: each scenario pushes the expected per-clock output words
// to a scoreboard queue; a negedge monitor pops and compares them.
module tb_tt_um_3515_sequence_generator;

  localparam int BC = 4;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       ena    = 1'b1;
  logic [7:0] ui_in  = 8'h00;
  logic [7:0] uio_in = 8'h00;
  wire  [7:0] uo_out;
  wire  [7:0] uio_out;
  wire  [7:0] uio_oe;

  typedef struct packed {
    logic [7:0] uo;
    logic [7:0] uio;
  } exp_t;

  exp_t  sb_q[$];
  int    n_cmp  = 0;
  int    n_err  = 0;
  logic  mon_on = 1'b0;
  string cur    = "none";

  always #5 clk = ~clk;

  tt_um_3515_sequence_generator #(.BIT_CYCLES(BC)) dut (
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .ena     (ena),
    .clk     (clk),
    .rst_n   (rst_n)
  );

  // Expected word: uo = {0, idx[2:0], 0, frame, strobe, sdata}; uio = {busy, done, 6'b0}
  function automatic exp_t mk(input logic sd, input logic st, input logic fr,
                              input logic [2:0] ix, input logic bz, input logic dn);
    exp_t e;
    e.uo  = {1'b0, ix, 1'b0, fr, st, sd};
    e.uio = {bz, dn, 6'b0};
    return e;
  endfunction

  function automatic void push_frame(input logic [7:0] pat, input int n,
                                     input int hold_bit, input int hold_after, input int hold_len);
    for (int b = n - 1; b >= 0; b--) begin
      for (int c = 0; c < BC; c++) begin
        sb_q.push_back(mk(pat[b], c == 0, 1'b1, b[2:0], 1'b1, 1'b0));
        if (b == hold_bit && c == hold_after)
          for (int h = 0; h < hold_len; h++)
            sb_q.push_back(mk(pat[b], c == 0, 1'b1, b[2:0], 1'b1, 1'b0));
      end
    end
  endfunction

  function automatic void push_done();
    sb_q.push_back(mk(1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1));
  endfunction

  function automatic void push_idle(input int k);
    for (int i = 0; i < k; i++)
      sb_q.push_back(mk(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0));
  endfunction

  // Scoreboard monitor: one comparison per clock, sampled on the falling edge.
  always @(negedge clk) begin
    if (mon_on) begin
      exp_t e;
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL %s stream: no expected entry, got uo_out=%h uio_out=%h at %0t",
                 cur, uo_out, uio_out, $time);
      end else begin
        e = sb_q.pop_front();
        if ({uo_out, uio_out} !== {e.uo, e.uio}) begin
          n_err++;
          $display("FAIL %s stream: got uo_out=%h uio_out=%h, want uo_out=%h uio_out=%h at %0t",
                   cur, uo_out, uio_out, e.uo, e.uio, $time);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic steps(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic drain(input int budget);
    int left = budget;
    while (sb_q.size() != 0 && left > 0) begin
      step();
      left--;
    end
    mon_on = 1'b0;
    n_cmp++;
    if (sb_q.size() !== 0) begin
      n_err++;
      $display("FAIL %s drain: %0d expected entries left, want 0", cur, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset();
    cur = "reset";
    #2;
    n_cmp += 3;
    if (uo_out !== 8'h00)  begin n_err++; $display("FAIL reset uo_out: got %h want 00", uo_out); end
    if (uio_out !== 8'h00) begin n_err++; $display("FAIL reset uio_out: got %h want 00", uio_out); end
    if (uio_oe !== 8'hC0)  begin n_err++; $display("FAIL reset uio_oe: got %h want c0", uio_oe); end
    step();
    rst_n = 1'b1;
    step();
    // Mid-frame reset of an all-ones pattern
    cur = "reset_mid";
    ui_in  = 8'hFF;
    uio_in = 8'h07;
    push_frame(8'hFF, 8, -1, 0, 0);
    mon_on = 1'b1;
    uio_in[3] = 1'b1;
    step();
    uio_in[3] = 1'b0;
    steps(9);
    mon_on = 1'b0;
    sb_q.delete();
    #2 rst_n = 1'b0;
    #1;
    n_cmp += 3;
    if (uo_out !== 8'h00)  begin n_err++; $display("FAIL reset_mid uo_out: got %h want 00", uo_out); end
    if (uio_out !== 8'h00) begin n_err++; $display("FAIL reset_mid uio_out: got %h want 00", uio_out); end
    if (uio_oe !== 8'hC0)  begin n_err++; $display("FAIL reset_mid uio_oe: got %h want c0", uio_oe); end
    step();
    rst_n = 1'b1;
    cur = "reset_idle";
    push_idle(4);
    mon_on = 1'b1;
    drain(20);
  endtask

  task automatic test_basic();
    cur = "basic";
    ui_in  = 8'hA5;
    uio_in = 8'h07;
    push_frame(8'hA5, 8, -1, 0, 0);
    push_done();
    push_idle(2);
    mon_on = 1'b1;
    uio_in[3] = 1'b1;
    step();
    uio_in[3] = 1'b0;
    drain(100);
  endtask

  task automatic test_short();
    cur = "short";
    ui_in  = 8'h04;
    uio_in = 8'h02;
    push_frame(8'h04, 3, -1, 0, 0);
    push_done();
    push_idle(2);
    mon_on = 1'b1;
    uio_in[3] = 1'b1;
    step();
    uio_in[3] = 1'b0;
    drain(100);
  endtask

  task automatic test_repeat();
    cur = "repeat";
    ui_in  = 8'h02;
    uio_in = 8'h11;
    for (int f = 0; f < 3; f++) push_frame(8'h02, 2, -1, 0, 0);
    push_done();
    push_idle(2);
    mon_on = 1'b1;
    uio_in[3] = 1'b1;
    step();
    uio_in[3] = 1'b0;
    steps(19);
    uio_in[4] = 1'b0;  // dropped during the third frame
    drain(100);
  endtask

  task automatic test_ignored();
    cur = "ignored";
    ui_in  = 8'hC3;
    uio_in = 8'h07;
    push_frame(8'hC3, 8, -1, 0, 0);
    push_done();
    push_idle(5);
    push_frame(8'h01, 1, -1, 0, 0);
    push_done();
    push_idle(2);
    mon_on = 1'b1;
    uio_in[3] = 1'b1;
    step();
    uio_in[3] = 1'b0;
    steps(2);
    uio_in = 8'h08;  // second rise plus new length field
    ui_in  = 8'h00;
    steps(2);
    uio_in[3] = 1'b0;
    steps(25);
    uio_in[3] = 1'b1;  // held high through the done pulse
    steps(7);
    ui_in  = 8'h01;
    uio_in = 8'h00;
    step();
    uio_in[3] = 1'b1;
    step();
    uio_in[3] = 1'b0;
    drain(100);
  endtask

  task automatic test_ena();
    cur = "ena";
    ui_in  = 8'hA5;
    uio_in = 8'h07;
    push_frame(8'hA5, 8, 6, 1, 5);
    push_done();
    push_idle(2);
    mon_on = 1'b1;
    uio_in[3] = 1'b1;
    step();
    uio_in[3] = 1'b0;
    steps(5);
    ena = 1'b0;
    steps(5);
    ena = 1'b1;
    drain(100);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_short();
    test_repeat();
    test_ignored();
    test_ena();
    steps(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tt_um_3515_sequence_generator.md
# tt_um_3515_sequence_generator

Serial bit-pattern transmitter, the driving end of the single-wire serial sequence interface used by our sequence-detector tiles. Captures a 1–8 bit pattern from the dedicated inputs on a start request and shifts it out MSB-first on one output pin. Each bit is held for a fixed number of clocks, and the pattern can optionally repeat. Busy, done and per-bit strobe flags let a bench or a downstream detector frame the stream.

## Interface
- BIT_CYCLES, 4: clocks per serial bit, ≥1; sized counter width = clog2(BIT_CYCLES)+1
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  global enable; when low all state and outputs hold
- ui_in  in  8  pattern byte; captured on accepted start
- uio_in  in  8  [2:0] length−1 (N = value+1 bits), [3] start (rising-edge sensitive), [4] repeat, [7:5] ignored
- uo_out  out  8  [0] sdata, [1] bit strobe, [2] frame, [3] 0, [7:4] current bit index (N−1 down to 0)
- uio_out  out  8  [7] busy, [6] done, [5:0] 0
- uio_oe  out  8  constant 8'hC0

## Operation
- States: IDLE, SEND, DONE.
- Start detect: registered start_q; rise = uio_in[3] & ~start_q; start_q updates only when ena high.
- IDLE: sdata=0, frame=0, busy=0. On rise: capture ui_in into pat_shadow and uio_in[2:0] into len_shadow; load idx=N−1, bit timer=0; go SEND.
- SEND: sdata = pat_shadow[idx]; frame=1; busy=1. Bit timer counts 0..BIT_CYCLES−1; at terminal count, if idx>0 decrement idx and restart timer; if idx==0 frame ends.
- Frame end: if uio_in[4]==1 (sampled at that edge) reload idx=len_shadow, stay in SEND with no gap cycle; else go DONE.
- DONE: one cycle, done=1, busy=1, sdata=0, frame=0; then IDLE.
- Start rises in SEND or DONE are ignored (start_q still tracks). ui_in/uio_in[2:0] changes after capture have no effect.
- Repeat cleared mid-frame: current frame completes, then DONE.
- ena low: timer, idx, state, start_q frozen; outputs hold; bit period stretches by the number of disabled cycles.
- Reset (any time, including mid-frame): state IDLE, all counters/shadows 0, every output bit 0 except uio_oe=8'hC0.

## Timing
- All outputs registered; no combinational input-to-output path.
- Rise seen at edge k ⇒ after edge k: busy=1, frame=1, sdata=first bit, strobe=1, index=N−1.
- Strobe: 1 for the first clock of every bit, else 0 (with BIT_CYCLES=1, strobe is constant 1 throughout SEND).
- Non-repeat frame: SEND lasts exactly N·BIT_CYCLES clocks (ena high); DONE is the next clock; IDLE after that. Earliest accepted restart is a rise sampled in IDLE, i.e. start must be low for at least one enabled edge first.
- Repeat: last bit of frame j is immediately followed by the first bit of frame j+1; period N·BIT_CYCLES.

## Structure
- Shared package seq_pkg: state enum (IDLE/SEND/DONE), BIT_CYCLES default, bit-position constants for start/repeat/length fields and busy/done/strobe/frame pins (the detector tile uses the same field map).
- One sub-module: seq_bit_timer (counter with ena, clear, terminal-count output, parameter BIT_CYCLES). The FSM and shift indexing live in the top.

## Test plan
- Reset: assert rst_n=0 mid-frame of pattern 0xFF → same-cycle async clear; uo_out=0, uio_out=0, uio_oe=8'hC0; after release, idle until a new start rise.
- Basic frame: ui_in=0xA5, length field=7, pulse start, BIT_CYCLES=4 → sdata 1,0,1,0,0,1,0,1, each bit 4 clocks; busy high 33 clocks; done high exactly 1 clock after clock 32; strobe 8 pulses.
- Short frame: ui_in=0x04, length field=2 → sdata 1,0,0 over 12 clocks, index 2,1,0; then done.
- Repeat: ui_in=0x02, length field=1, repeat=1 → continuous 1,0,1,0… with no gap; drop repeat during the 3rd frame → frame 3 completes, then a done pulse, then idle.
- Ignored inputs: second start rise and ui_in change to 0x00 during SEND → output stream unchanged; start held high across the done pulse → no restart until it goes low then high.
- ena freeze: drop ena for 5 clocks in the middle of bit 2 → that bit lasts 9 clocks; other bits 4; done timing shifted by 5.
